uart_tx_word: RTL and testbench
===============================

Name: uart_tx_word

Overview:
- UART transmitter that serialises 16-bit sample words as 8N1 frames, low byte first, onto a single line at TICKS_PER_BIT clocks per bit.
- Mates with the team's UART receiver and uses the same bit timing and active-low completion-flag style.
- Sits between the FFT output path and the board TX pin.
- A one-word holding register lets the next word queue during the current frame, so words go out back-to-back with no idle gap.

Parameters:
- TICKS_PER_BIT, 128, clocks per bit; legal range 2..65535.
- BYTES_PER_WORD, 2, bytes sent per accepted word; 1 sends i_tx_word[7:0] only, 2 sends [7:0] then [15:8].
- STOP_BITS, 1, stop bits per byte; 1 or 2.

Ports:
- i_clk  input  1  clock, rising-edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_tx_valid  input  1  word offered.
- i_tx_word  input  16  word to send; sampled only on acceptance.
- o_tx_ready  output  1  holding register empty; word accepted on an edge where i_tx_valid & o_tx_ready.
- o_tx_serial  output  1  serial line, idle high, registered.
- o_tx_active  output  1  high while a frame (start..last stop) is on the line.
- o_tx_flag  output  1  active-low one-cycle pulse when a whole word has finished.

Behaviour:
- Reset is synchronous, active-high, on i_clk. While i_rst is high at an edge:
  - o_tx_serial=1, o_tx_active=0, o_tx_flag=1, o_tx_ready=0.
  - Holding register empty; state=IDLE; counters=0.
  - o_tx_ready rises the first cycle after i_rst falls.
- Reset mid-frame aborts immediately: the line returns high at the next edge, the partially sent byte and any queued word are discarded, and no flag pulse is issued.
- Holding register:
  - Acceptance at edge k sets it full.
  - o_tx_ready=!full; the registered value is low from k unless the engine drains it at the same edge.
  - i_tx_valid while o_tx_ready=0 is ignored; the producer must hold it.
- States:
  - IDLE: line high, o_tx_active=0. If holding full, at the next edge: load the shifter and byte index 0, empty holding, go START.
  - START: line 0 for TICKS_PER_BIT cycles, then go DATA.
  - DATA: 8 bits LSB first, each TICKS_PER_BIT cycles, then go STOP.
  - STOP: line 1 for STOP_BITS*TICKS_PER_BIT cycles. At the end:
    - More bytes remain in the word: increment byte index, go START with no gap.
    - Last byte: pulse o_tx_flag low for exactly the next cycle. If holding is full, load it and go START (no idle cycle); else go IDLE.
- Timing: a word accepted at edge k with the engine idle has its start bit on the line from k+1.
  - Byte time = (9+STOP_BITS)*TICKS_PER_BIT cycles.
  - Word time = BYTES_PER_WORD*(byte time).
- Tick counter is 16 bits, counting 0..TICKS_PER_BIT-1 with wrap to 0 at each bit boundary. Bit edges never drift.
- o_tx_active is high from the first start-bit cycle to the last stop-bit cycle inclusive. It stays high across byte and back-to-back word boundaries.
- o_tx_serial changes only on tick-counter wrap or load, so it is glitch-free. Its value is a register, not decoded combinationally.
- Simultaneous events:
  - Acceptance on the same edge the engine drains holding is legal. The new word enters holding and o_tx_ready stays low.
  - Flag pulse and next start bit may coincide.
- Illegal parameter values (TICKS_PER_BIT<2, BYTES_PER_WORD or STOP_BITS outside 1..2) must fail elaboration.

Test Plan:
- TPB=8, BPW=2, SB=1: reset, then send 0xA55A.
  -> Line shows 0,[0,1,0,1,1,0,1,0],1 then 0,[1,0,1,0,0,1,0,1],1.
  -> Each bit 8 cycles; start bit from k+1.
  -> o_tx_flag low for one cycle at k+161; o_tx_active high 160 cycles.
- Back-to-back: hold valid with 0x0001 then 0xFFFF.
  -> Second word accepted during the first frame; o_tx_ready low until the drain.
  -> No idle cycle between frames; two flag pulses 160 cycles apart.
  -> Bytes received by the team's UART receiver in loopback: 01,00,FF,FF.
- BPW=1: send 0x12C3.
  -> Only 0xC3 is framed; flag after 80 cycles; upper byte never appears.
- Reset mid-frame: assert i_rst during data bit 3 of the low byte with a word queued.
  -> Line 1 at the next edge; ready/active/flag at reset values; no flag pulse; queued word never sent.
  -> Next word after release starts cleanly.
- SB=2, TPB=8: send 0x0055.
  -> Each stop period high for 16 cycles; word time 176 cycles.
  -> Toggling i_tx_valid while ready=0 causes no extra acceptance.

Source files
------------

// File: rtl/uart_tx_word_if.sv
// uart_tx_word_if: word handshake and serial-line signals between a producer and uart_tx_word
interface uart_tx_word_if;
    logic        i_tx_valid;
    logic [15:0] i_tx_word;
    logic        o_tx_ready;
    logic        o_tx_serial;
    logic        o_tx_active;
    logic        o_tx_flag;
    modport master (
        output i_tx_valid, i_tx_word,
        input  o_tx_ready, o_tx_serial, o_tx_active, o_tx_flag
    );
    modport slave (
        input  i_tx_valid, i_tx_word,
        output o_tx_ready, o_tx_serial, o_tx_active, o_tx_flag
    );
endinterface

// File: rtl/uart_tx_word.sv
// uart_tx_word: 8N1 UART transmitter for 16-bit words, low byte first, with a one-word holding register
module uart_tx_word #(
    parameter int TICKS_PER_BIT  = 128,
    parameter int BYTES_PER_WORD = 2,
    parameter int STOP_BITS      = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    uart_tx_word_if.slave bus
);
    if (TICKS_PER_BIT < 2 || TICKS_PER_BIT > 65535) begin : g_bad_tpb
        $error("TICKS_PER_BIT must be 2..65535");
    end
    if (BYTES_PER_WORD < 1 || BYTES_PER_WORD > 2) begin : g_bad_bpw
        $error("BYTES_PER_WORD must be 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
        $error("STOP_BITS must be 1 or 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] TICK_MAX  = 16'(TICKS_PER_BIT - 1);
    localparam logic        LAST_BYTE = 1'(BYTES_PER_WORD - 1);
    localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

    state_t      state;
    logic [15:0] tick;
    logic [15:0] hold;
    logic [7:0]  shifter;
    logic [7:0]  upper;
    logic [2:0]  bit_idx;
    logic        byte_idx;
    logic        stop_idx;
    logic        full;
    logic        ready;
    logic        serial;
    logic        active;
    logic        flag;
    logic        wrap;
    logic        word_end;
    logic        drain;
    logic        accept;
    logic        full_next;

    // The engine takes the holding word when idle or exactly as the last stop bit of a word ends,
    // which is what keeps back-to-back words gap-free.
    assign wrap      = tick == TICK_MAX;
    assign word_end  = state == STOP && wrap && stop_idx == LAST_STOP && byte_idx == LAST_BYTE;
    assign drain     = full && (state == IDLE || word_end);
    assign accept    = bus.i_tx_valid && ready;
    assign full_next = accept || (full && !drain);

    assign bus.o_tx_ready  = ready;
    assign bus.o_tx_serial = serial;
    assign bus.o_tx_active = active;
    assign bus.o_tx_flag   = flag;

    // Frame FSM, holding register and registered line outputs; a load from holding overrides the state step
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            tick     <= '0;
            hold     <= '0;
            shifter  <= '0;
            upper    <= '0;
            bit_idx  <= '0;
            byte_idx <= 1'b0;
            stop_idx <= 1'b0;
            full     <= 1'b0;
            ready    <= 1'b0;
            serial   <= 1'b1;
            active   <= 1'b0;
            flag     <= 1'b1;
        end else begin
            full  <= full_next;
            ready <= !full_next;
            flag  <= 1'b1;
            tick  <= (state == IDLE || wrap) ? '0 : tick + 16'd1;
            if (accept)
                hold <= bus.i_tx_word;
            case (state)
                START: if (wrap) begin
                    state   <= DATA;
                    serial  <= shifter[0];
                    shifter <= shifter >> 1;
                    bit_idx <= '0;
                end
                DATA: if (wrap) begin
                    if (bit_idx == 3'd7) begin
                        state    <= STOP;
                        serial   <= 1'b1;
                        stop_idx <= 1'b0;
                    end else begin
                        serial  <= shifter[0];
                        shifter <= shifter >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: if (wrap) begin
                    if (stop_idx != LAST_STOP) begin
                        stop_idx <= stop_idx + 1'b1;
                    end else if (byte_idx != LAST_BYTE) begin
                        state    <= START;
                        byte_idx <= byte_idx + 1'b1;
                        shifter  <= upper;
                        serial   <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        flag   <= 1'b0;
                        active <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (drain) begin
                state    <= START;
                shifter  <= hold[7:0];
                upper    <= hold[15:8];
                byte_idx <= 1'b0;
                serial   <= 1'b0;
                active   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_word.sv
// tb_uart_tx_word: directed self-checking bench for uart_tx_word in three parameter configurations
module tb_uart_tx_word;
    localparam int TPB = 8;
    localparam int BPW [3] = '{2, 1, 2};
    localparam int SB  [3] = '{1, 1, 2};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  valid;
    logic [15:0] word [3];
    logic [2:0]  ser, act, flg, rdy;
    int          n_checks = 0;
    int          n_fail = 0;
    int          acc;
    logic        ser_q [$];
    logic        act_q [$];
    logic        flg_q [$];
    logic        rdy_q [$];
    logic [7:0]  rx_q [$];

    always #5 clk = ~clk;

    uart_tx_word_if if0 ();
    uart_tx_word_if if1 ();
    uart_tx_word_if if2 ();

    uart_tx_word #(.TICKS_PER_BIT(TPB), .BYTES_PER_WORD(2), .STOP_BITS(1)) dut0 (.i_clk(clk), .i_rst(rst), .bus(if0.slave));
    uart_tx_word #(.TICKS_PER_BIT(TPB), .BYTES_PER_WORD(1), .STOP_BITS(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(if1.slave));
    uart_tx_word #(.TICKS_PER_BIT(TPB), .BYTES_PER_WORD(2), .STOP_BITS(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(if2.slave));

    assign if0.i_tx_valid = valid[0];
    assign if1.i_tx_valid = valid[1];
    assign if2.i_tx_valid = valid[2];
    assign if0.i_tx_word  = word[0];
    assign if1.i_tx_word  = word[1];
    assign if2.i_tx_word  = word[2];
    assign ser = {if2.o_tx_serial, if1.o_tx_serial, if0.o_tx_serial};
    assign act = {if2.o_tx_active, if1.o_tx_active, if0.o_tx_active};
    assign flg = {if2.o_tx_flag, if1.o_tx_flag, if0.o_tx_flag};
    assign rdy = {if2.o_tx_ready, if1.o_tx_ready, if0.o_tx_ready};

    task automatic check(string tag, int got, int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level n cycles after the acceptance edge of a word sent into an idle engine
    function automatic logic exp_line(logic [15:0] w, int bpw, int sb, int n);
        int bt = (9 + sb) * TPB;
        int m, pos;
        logic [7:0] by;
        if (n < 1 || n > bpw * bt) return 1'b1;
        m   = n - 1;
        by  = (m / bt) != 0 ? w[15:8] : w[7:0];
        pos = (m % bt) / TPB;
        if (pos == 0) return 1'b0;
        if (pos <= 8) return by[pos-1];
        return 1'b1;
    endfunction

    function automatic logic exp2(int d, logic [15:0] w1, logic two, logic [15:0] w2, int n);
        int wt = BPW[d] * (9 + SB[d]) * TPB;
        if (n <= wt || !two) return exp_line(w1, BPW[d], SB[d], n);
        return exp_line(w2, BPW[d], SB[d], n - wt);
    endfunction

    // Independent receiver model: find start bits and sample each cell in its middle
    function automatic void decode();
        int i = 0;
        logic [7:0] b;
        rx_q.delete();
        while (i + 9 * TPB + TPB / 2 < ser_q.size()) begin
            if (ser_q[i] == 1'b0) begin
                for (int j = 0; j < 8; j++) b[j] = ser_q[i + (j + 1) * TPB + TPB / 2];
                if (ser_q[i + 9 * TPB + TPB / 2]) rx_q.push_back(b);
                i += 9 * TPB + TPB / 2;
            end else begin
                i++;
            end
        end
    endfunction

    task automatic offer(int d, logic [15:0] w);
        int t = 0;
        @(negedge clk);
        valid[d] = 1'b1;
        word[d]  = w;
        while (!rdy[d] && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("offer_ready", int'(rdy[d]), 1);
    endtask

    // Sample n=0..ncyc after the acceptance edge; optionally hold a second word and toggle valid afterwards
    task automatic capture(int d, int ncyc, logic two, logic [15:0] w2, int tog_until);
        ser_q.delete();
        act_q.delete();
        flg_q.delete();
        rdy_q.delete();
        acc = 0;
        for (int n = 0; n <= ncyc; n++) begin
            @(negedge clk);
            ser_q.push_back(ser[d]);
            act_q.push_back(act[d]);
            flg_q.push_back(flg[d]);
            rdy_q.push_back(rdy[d]);
            if (n == 0) begin
                if (two) word[d] = w2;
                else valid[d] = 1'b0;
            end else if (two && acc == 0) begin
                valid[d] = 1'b1;
            end else if (n <= tog_until) begin
                valid[d] = n[0];
                word[d]  = 16'h1234;
            end else begin
                valid[d] = 1'b0;
            end
            if (valid[d] && rdy[d]) acc++;
        end
    endtask

    task automatic verify(int d, logic [15:0] w1, logic two, logic [15:0] w2, string tag);
        int wt = BPW[d] * (9 + SB[d]) * TPB;
        int span = two ? 2 * wt : wt;
        int bad = 0, act_bad = 0, n_low = 0, first_low = -1, last_low = -1;
        logic e;
        for (int n = 0; n < ser_q.size(); n++) begin
            e = exp2(d, w1, two, w2, n);
            if (ser_q[n] !== e) bad++;
            if (n >= 1 && n <= span && (n - 1) % TPB == TPB / 2) check({tag, "_bit"}, int'(ser_q[n]), int'(e));
            if (act_q[n] !== (n >= 1 && n <= span)) act_bad++;
            if (!flg_q[n]) begin
                n_low++;
                if (first_low < 0) first_low = n;
                last_low = n;
            end
        end
        check({tag, "_line_errs"}, bad, 0);
        check({tag, "_active_errs"}, act_bad, 0);
        check({tag, "_flag_count"}, n_low, two ? 2 : 1);
        check({tag, "_flag_first"}, first_low, wt + 1);
        check({tag, "_flag_last"}, last_low, span + 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int highs, lows, acts;
        valid = '0;
        for (int i = 0; i < 3; i++) word[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_serial", int'(ser), 7);
        check("rst_active", int'(act), 0);
        check("rst_flag", int'(flg), 7);
        check("rst_ready", int'(rdy), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", int'(rdy), 7);

        offer(0, 16'hA55A);
        capture(0, 180, 1'b0, 16'h0, 0);
        verify(0, 16'hA55A, 1'b0, 16'h0, "a55a");
        check("a55a_ready_k", int'(rdy_q[0]), 0);
        check("a55a_ready_k1", int'(rdy_q[1]), 1);
        decode();
        check("a55a_rx_n", rx_q.size(), 2);
        check("a55a_rx0", int'(rx_q[0]), 'h5A);
        check("a55a_rx1", int'(rx_q[1]), 'hA5);

        offer(0, 16'h0001);
        capture(0, 340, 1'b1, 16'hFFFF, 0);
        verify(0, 16'h0001, 1'b1, 16'hFFFF, "b2b");
        check("b2b_accepts", acc, 1);
        check("b2b_ready_k2", int'(rdy_q[2]), 0);
        check("b2b_ready_pre_drain", int'(rdy_q[160]), 0);
        check("b2b_ready_drained", int'(rdy_q[161]), 1);
        decode();
        check("b2b_rx_n", rx_q.size(), 4);
        check("b2b_rx0", int'(rx_q[0]), 'h01);
        check("b2b_rx1", int'(rx_q[1]), 'h00);
        check("b2b_rx2", int'(rx_q[2]), 'hFF);
        check("b2b_rx3", int'(rx_q[3]), 'hFF);

        offer(1, 16'h12C3);
        capture(1, 100, 1'b0, 16'h0, 0);
        verify(1, 16'h12C3, 1'b0, 16'h0, "bpw1");
        decode();
        check("bpw1_rx_n", rx_q.size(), 1);
        check("bpw1_rx0", int'(rx_q[0]), 'hC3);

        offer(0, 16'h1234);
        capture(0, 35, 1'b1, 16'hBEEF, 0);
        check("mid_queued", acc, 1);
        check("mid_bit3", int'(ser_q[35]), int'(exp_line(16'h1234, 2, 1, 35)));
        check("mid_active", int'(act_q[35]), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_serial", int'(ser[0]), 1);
        check("mid_rst_active", int'(act[0]), 0);
        check("mid_rst_flag", int'(flg[0]), 1);
        check("mid_rst_ready", int'(rdy[0]), 0);
        rst = 1'b0;
        capture(0, 200, 1'b0, 16'h0, 0);
        highs = 0;
        lows = 0;
        acts = 0;
        foreach (ser_q[i]) begin
            highs += int'(ser_q[i]);
            lows  += int'(!flg_q[i]);
            acts  += int'(act_q[i]);
        end
        check("post_rst_ready", int'(rdy_q[0]), 1);
        check("post_rst_line_high", highs, ser_q.size());
        check("post_rst_no_flag", lows, 0);
        check("post_rst_no_active", acts, 0);
        offer(0, 16'h00F0);
        capture(0, 180, 1'b0, 16'h0, 0);
        verify(0, 16'h00F0, 1'b0, 16'h0, "clean");
        decode();
        check("clean_rx_n", rx_q.size(), 2);
        check("clean_rx0", int'(rx_q[0]), 'hF0);
        check("clean_rx1", int'(rx_q[1]), 'h00);

        offer(2, 16'h0055);
        capture(2, 370, 1'b1, 16'h00AA, 170);
        verify(2, 16'h0055, 1'b1, 16'h00AA, "sb2");
        check("sb2_accepts", acc, 1);
        highs = 0;
        for (int n = 73; n <= 88; n++) highs += int'(ser_q[n]);
        check("sb2_stop_high", highs, 16);
        check("sb2_bit7_low", int'(ser_q[72]), 0);
        check("sb2_next_start", int'(ser_q[89]), 0);
        decode();
        check("sb2_rx_n", rx_q.size(), 4);
        check("sb2_rx0", int'(rx_q[0]), 'h55);
        check("sb2_rx1", int'(rx_q[1]), 'h00);
        check("sb2_rx2", int'(rx_q[2]), 'hAA);
        check("sb2_rx3", int'(rx_q[3]), 'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
